// File: rtl/frogger_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : frogger_game_sequencer
// Purpose  : Game-flow controller for Frogger_Game. Sequences start, play,
//            hit recovery, level-up and game over; owns lives, level and
//            score; configures the obstacle datapath (car enable / period)
//            and pulses a frog re-spawn request.
// Ports    : i_Clk, i_Rst_L (async active-low)
//            i_Start, i_Has_Collided, i_Frog_Reached_Top : level inputs,
//                rising edge acts as an event
//            o_State       : 0 IDLE, 1 PLAY, 2 HIT, 3 LEVEL_UP, 4 GAME_OVER
//            o_Frog_Reset  : one-cycle re-spawn pulse
//            o_Cars_Enable : high only in PLAY
//            o_Car_Period  : clocks per car step
//            o_Lives, o_Level, o_Score : game counters
// Revision : 1.0  initial release
// ============================================================================
module frogger_game_sequencer #(
    parameter int c_LIVES_INI   = 3,
    parameter int c_MAX_LEVEL   = 7,
    parameter int c_HOLD_CYCLES = 25_000_000,
    parameter int c_BASE_PERIOD = 500_000,
    parameter int c_PERIOD_STEP = 50_000,
    parameter int c_MIN_PERIOD  = 100_000,
    parameter int c_SCORE_MAX   = 99
) (
    input  logic        i_Clk,
    input  logic        i_Rst_L,
    input  logic        i_Start,
    input  logic        i_Has_Collided,
    input  logic        i_Frog_Reached_Top,
    output logic [2:0]  o_State,
    output logic        o_Frog_Reset,
    output logic        o_Cars_Enable,
    output logic [23:0] o_Car_Period,
    output logic [1:0]  o_Lives,
    output logic [2:0]  o_Level,
    output logic [6:0]  o_Score
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PLAY      = 3'd1,
        ST_HIT       = 3'd2,
        ST_LEVEL_UP  = 3'd3,
        ST_GAME_OVER = 3'd4
    } state_t;

    localparam int              c_TW         = (c_HOLD_CYCLES > 2) ? $clog2(c_HOLD_CYCLES) : 1;
    localparam logic [c_TW-1:0] c_TIMER_LAST = c_TW'(c_HOLD_CYCLES - 1);

    state_t            state_q;
    logic [c_TW-1:0]   timer_q;
    logic              start_prev_q;
    logic              coll_prev_q;
    logic              top_prev_q;
    logic              frog_reset_q;
    logic              cars_enable_q;
    logic [23:0]       car_period_q;
    logic [1:0]        lives_q;
    logic [2:0]        level_q;
    logic [6:0]        score_q;

    logic              w_start_evt;
    logic              w_coll_evt;
    logic              w_top_evt;
    logic [24:0]       w_period_diff;
    logic [23:0]       w_period_d;

    assign w_start_evt = i_Start            & ~start_prev_q;
    assign w_coll_evt  = i_Has_Collided     & ~coll_prev_q;
    assign w_top_evt   = i_Frog_Reached_Top & ~top_prev_q;

    // Extra MSB makes a subtraction past zero show up as a set sign bit
    // instead of wrapping to a huge period.
    assign w_period_diff = {1'b0, car_period_q} - 25'(c_PERIOD_STEP);
    assign w_period_d    = (w_period_diff[24] || (w_period_diff < 25'(c_MIN_PERIOD)))
                           ? 24'(c_MIN_PERIOD) : w_period_diff[23:0];

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q       <= ST_IDLE;
            timer_q       <= '0;
            start_prev_q  <= 1'b0;
            coll_prev_q   <= 1'b0;
            top_prev_q    <= 1'b0;
            frog_reset_q  <= 1'b0;
            cars_enable_q <= 1'b0;
            car_period_q  <= 24'(c_BASE_PERIOD);
            lives_q       <= 2'(c_LIVES_INI);
            level_q       <= 3'd0;
            score_q       <= 7'd0;
        end else begin
            start_prev_q <= i_Start;
            coll_prev_q  <= i_Has_Collided;
            top_prev_q   <= i_Frog_Reached_Top;
            frog_reset_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    cars_enable_q <= 1'b0;
                    if (w_start_evt) begin
                        state_q       <= ST_PLAY;
                        frog_reset_q  <= 1'b1;
                        cars_enable_q <= 1'b1;
                    end
                end

                ST_PLAY: begin
                    // Collision takes priority over reaching the goal row.
                    if (w_coll_evt) begin
                        cars_enable_q <= 1'b0;
                        timer_q       <= '0;
                        if (lives_q > 2'd1) begin
                            lives_q <= lives_q - 2'd1;
                            state_q <= ST_HIT;
                        end else begin
                            lives_q <= 2'd0;
                            state_q <= ST_GAME_OVER;
                        end
                    end else if (w_top_evt) begin
                        cars_enable_q <= 1'b0;
                        timer_q       <= '0;
                        state_q       <= ST_LEVEL_UP;
                        car_period_q  <= w_period_d;
                        if (score_q != 7'(c_SCORE_MAX)) score_q <= score_q + 7'd1;
                        if (level_q != 3'(c_MAX_LEVEL)) level_q <= level_q + 3'd1;
                    end
                end

                ST_HIT, ST_LEVEL_UP: begin
                    if (timer_q == c_TIMER_LAST) begin
                        timer_q       <= '0;
                        state_q       <= ST_PLAY;
                        frog_reset_q  <= 1'b1;
                        cars_enable_q <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                ST_GAME_OVER: begin
                    cars_enable_q <= 1'b0;
                    if (w_start_evt) begin
                        lives_q       <= 2'(c_LIVES_INI);
                        level_q       <= 3'd0;
                        score_q       <= 7'd0;
                        car_period_q  <= 24'(c_BASE_PERIOD);
                        state_q       <= ST_PLAY;
                        frog_reset_q  <= 1'b1;
                        cars_enable_q <= 1'b1;
                    end
                end

                default: begin
                    state_q       <= ST_IDLE;
                    timer_q       <= '0;
                    cars_enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_State       = state_q;
    assign o_Frog_Reset  = frog_reset_q;
    assign o_Cars_Enable = cars_enable_q;
    assign o_Car_Period  = car_period_q;
    assign o_Lives       = lives_q;
    assign o_Level       = level_q;
    assign o_Score       = score_q;

endmodule
`default_nettype wire

// File: tb/tb_frogger_game_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_frogger_game_sequencer
// Purpose  : Directed self-checking bench for frogger_game_sequencer with a
//            short pause (4 clocks) and small car periods.
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_frogger_game_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        coll;
    logic        top;
    logic [2:0]  state;
    logic        frog_reset;
    logic        cars_en;
    logic [23:0] period;
    logic [1:0]  lives;
    logic [2:0]  level;
    logic [6:0]  score;

    int checks   = 0;
    int failures = 0;

    frogger_game_sequencer #(
        .c_LIVES_INI   (3),
        .c_MAX_LEVEL   (7),
        .c_HOLD_CYCLES (4),
        .c_BASE_PERIOD (100),
        .c_PERIOD_STEP (30),
        .c_MIN_PERIOD  (20),
        .c_SCORE_MAX   (99)
    ) u_dut (
        .i_Clk              (clk),
        .i_Rst_L            (rst_n),
        .i_Start            (start),
        .i_Has_Collided     (coll),
        .i_Frog_Reached_Top (top),
        .o_State            (state),
        .o_Frog_Reset       (frog_reset),
        .o_Cars_Enable      (cars_en),
        .o_Car_Period       (period),
        .o_Lives            (lives),
        .o_Level            (level),
        .o_Score            (score)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic check_all(input string tag, input int st, input int fr, input int ce,
                             input int per, input int lv, input int lvl, input int sc);
        check_val({tag, ".state"},  int'(state),      st);
        check_val({tag, ".frog"},   int'(frog_reset), fr);
        check_val({tag, ".cars"},   int'(cars_en),    ce);
        check_val({tag, ".period"}, int'(period),     per);
        check_val({tag, ".lives"},  int'(lives),      lv);
        check_val({tag, ".level"},  int'(level),      lvl);
        check_val({tag, ".score"},  int'(score),      sc);
    endtask

    int exp_period [3] = '{70, 40, 20};

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        coll  = 1'b0;
        top   = 1'b0;
        step(3);
        check_all("reset", 0, 0, 0, 100, 3, 0, 0);
        rst_n = 1'b1;
        step(2);
        check_all("idle", 0, 0, 0, 100, 3, 0, 0);

        // 1. start -> PLAY with a single re-spawn pulse
        start = 1'b1;
        step(1);
        check_all("start", 1, 1, 1, 100, 3, 0, 0);
        step(1);
        check_val("start.pulse_end", int'(frog_reset), 0);
        check_val("start.still_play", int'(state), 1);
        start = 1'b0;
        step(1);

        // 2. held collision: one decrement, 4-cycle HIT, then PLAY
        coll = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            check_all($sformatf("hit%0d", i), 2, 0, 0, 100, 2, 0, 0);
        end
        step(1);
        check_all("hit.exit", 1, 1, 1, 100, 2, 0, 0);
        step(1);
        check_all("hit.after", 1, 0, 1, 100, 2, 0, 0);
        coll = 1'b0;
        step(1);

        // 3. three crossings: level/score up, period 70, 40, 20 (floor)
        for (int k = 0; k < 3; k++) begin
            top = 1'b1;
            step(1);
            check_all($sformatf("lvl%0d", k), 3, 0, 0, exp_period[k], 3 - 1, k + 1, k + 1);
            top = 1'b0;
            step(3);
            check_val($sformatf("lvl%0d.hold", k), int'(state), 3);
            step(1);
            check_all($sformatf("lvl%0d.exit", k), 1, 1, 1, exp_period[k], 2, k + 1, k + 1);
            step(1);
        end

        // lose a life to get down to 1
        coll = 1'b1;
        step(1);
        check_val("hit2.lives", int'(lives), 1);
        coll = 1'b0;
        step(4);
        check_val("hit2.exit", int'(state), 1);
        step(1);

        // 4. simultaneous collision and top with lives=1 -> GAME_OVER
        coll = 1'b1;
        top  = 1'b1;
        step(1);
        check_all("gameover", 4, 0, 0, 20, 0, 3, 3);
        coll = 1'b0;
        top  = 1'b0;
        step(2);
        check_all("gameover.hold", 4, 0, 0, 20, 0, 3, 3);

        // 5. restart from GAME_OVER reloads everything
        start = 1'b1;
        step(1);
        check_all("restart", 1, 1, 1, 100, 3, 0, 0);
        start = 1'b0;
        step(1);

        // 6. async reset mid-pause (timer=2) clears outputs, no pulse
        coll = 1'b1;
        step(3);
        check_val("rst.pre_state", int'(state), 2);
        rst_n = 1'b0;
        #1;
        check_all("rst.async", 0, 0, 0, 100, 3, 0, 0);
        step(2);
        check_val("rst.hold_frog", int'(frog_reset), 0);
        rst_n = 1'b1;
        step(1);
        check_all("rst.release", 0, 0, 0, 100, 3, 0, 0);
        coll = 1'b0;
        step(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
